// File: rtl/clk_ratio_meter.sv
// clk_ratio_meter: measures period and high time of an async clock
// in clkin cycles, with frequency lock and loss-of-clock flags.
module clk_ratio_meter #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1024,
  parameter int LOCK_CNT    = 4,
  parameter int TOL         = 1
) (
  input  logic             clkin,
  input  logic             rst_n,
  input  logic             meas_en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             period_valid,
  output logic             locked,
  output logic             lost
);

  localparam int MW = $clog2(LOCK_CNT + 1);

  localparam logic [CNT_W-1:0] CMAX  = '1;
  localparam logic [CNT_W-1:0] TO_V  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TOL_V = CNT_W'(TOL);
  localparam logic [MW-1:0]    LCK_V = MW'(LOCK_CNT);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_EDGE,
    MEASURE,
    LOST
  } state_t;

  state_t state;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   s_d;
  logic                   rise;
  logic                   fall;

  logic [CNT_W-1:0] pcnt;
  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] diff;
  logic             in_tol;
  logic             tmo;

  logic [MW-1:0] match_cnt;
  logic [MW-1:0] match_nx;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

  // Synchronize sig_in and keep one delayed copy for edge detect
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      s_d    <= s;
    end
  end

  // Period and high-time counters, restarted by each rising edge
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
      hcnt <= '0;
    end else if (state == IDLE) begin
      pcnt <= '0;
      hcnt <= '0;
    end else begin
      if (rise) begin
        pcnt <= CNT_W'(1);
      end else if (pcnt != CMAX) begin
        pcnt <= pcnt + CNT_W'(1);
      end
      if (rise) begin
        hcnt <= CNT_W'(1);
      end else if (s && hcnt != CMAX) begin
        hcnt <= hcnt + CNT_W'(1);
      end
    end
  end

  // Distance of the new period from the previous one
  always_comb begin
    diff = '0;
    if (pcnt >= period) begin
      diff = pcnt - period;
    end else begin
      diff = period - pcnt;
    end
  end

  assign in_tol   = (diff <= TOL_V);
  assign tmo      = (pcnt == TO_V);
  assign match_nx = (match_cnt == LCK_V) ?
                    match_cnt : match_cnt + MW'(1);

  // Measurement FSM with registered outputs
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      period       <= '0;
      high_time    <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      lost         <= 1'b0;
      match_cnt    <= '0;
    end else begin
      period_valid <= 1'b0;
      if (!meas_en) begin
        state     <= IDLE;
        locked    <= 1'b0;
        lost      <= 1'b0;
        match_cnt <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            state <= WAIT_EDGE;
          end
          WAIT_EDGE: begin
            if (rise) begin
              state <= MEASURE;
            end else if (tmo) begin
              state     <= LOST;
              lost      <= 1'b1;
              locked    <= 1'b0;
              match_cnt <= '0;
            end
          end
          MEASURE: begin
            if (rise) begin
              period       <= pcnt;
              period_valid <= 1'b1;
              if (in_tol) begin
                match_cnt <= match_nx;
                if (match_nx == LCK_V) begin
                  locked <= 1'b1;
                end
              end else begin
                match_cnt <= '0;
                locked    <= 1'b0;
              end
            end else if (tmo) begin
              state     <= LOST;
              lost      <= 1'b1;
              locked    <= 1'b0;
              match_cnt <= '0;
            end
            if (fall) begin
              high_time <= hcnt;
            end
          end
          LOST: begin
            locked    <= 1'b0;
            match_cnt <= '0;
            if (rise) begin
              state <= MEASURE;
              lost  <= 1'b0;
            end
          end
        endcase
      end
    end
  end

endmodule
